// File: rtl/cpu_pkg.sv
// cpu_pkg: shared MEM-stage types and constants.
// Holds the MEM FSM states, WB field bit indices and the WB bubble value.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam logic [1:0] WB_BUBBLE = 2'b00;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: data-memory req/ack bus between the MEM stage and dmem.
// master = MEM stage side, slave = memory side.
interface mem_wb_stage_if #(
    parameter int XLEN = 32
);

    logic            dmem_req_o;
    logic            dmem_we_o;
    logic [XLEN-1:0] dmem_addr_o;
    logic [XLEN-1:0] dmem_wdata_o;
    logic            dmem_ack_i;
    logic [XLEN-1:0] dmem_rdata_i;

    modport master (
        output dmem_req_o,
        output dmem_we_o,
        output dmem_addr_o,
        output dmem_wdata_o,
        input  dmem_ack_i,
        input  dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o,
        input  dmem_we_o,
        input  dmem_addr_o,
        input  dmem_wdata_o,
        output dmem_ack_i,
        output dmem_rdata_i
    );

endinterface

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register.
// load_i=1 captures the presented fields, load_i=0 inserts a bubble.
module mem_wb_reg #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [1:0]      wb_i,
    input  logic [XLEN-1:0] alu_i,
    input  logic [XLEN-1:0] mem_i,
    input  logic [4:0]      rd_i,
    output logic            reg_write_o,
    output logic            mem_to_reg_o,
    output logic [XLEN-1:0] alu_o,
    output logic [XLEN-1:0] mem_o,
    output logic [4:0]      rd_o
);

    import cpu_pkg::*;

    logic [1:0]      wb_q, wb_d;
    logic [XLEN-1:0] alu_q, alu_d;
    logic [XLEN-1:0] mem_q, mem_d;
    logic [4:0]      rd_q, rd_d;

    always_comb begin
        wb_d  = WB_BUBBLE;
        alu_d = '0;
        mem_d = '0;
        rd_d  = '0;
        if (load_i) begin
            wb_d  = wb_i;
            alu_d = alu_i;
            mem_d = mem_i;
            rd_d  = rd_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wb_q  <= WB_BUBBLE;
            alu_q <= '0;
            mem_q <= '0;
            rd_q  <= '0;
        end else begin
            wb_q  <= wb_d;
            alu_q <= alu_d;
            mem_q <= mem_d;
            rd_q  <= rd_d;
        end
    end

    assign reg_write_o  = wb_q[WB_REGWRITE];
    assign mem_to_reg_o = wb_q[WB_MEMTOREG];
    assign alu_o        = alu_q;
    assign mem_o        = mem_q;
    assign rd_o         = rd_q;

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage FSM driving dmem over req/ack, plus the MEM/WB register.
// Define MEM_ALIGN_CHECK_EN to drop misaligned accesses and pulse misalign_o.
module mem_wb_stage #(
    parameter int ACK_TIMEOUT = 255,
    parameter int XLEN        = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [1:0]      WB_i,
    input  logic            MEMR_i,
    input  logic            MEMW_i,
    input  logic [XLEN-1:0] ALUout_i,
    input  logic [XLEN-1:0] RS2_i,
    input  logic [4:0]      RDaddr_i,
    output logic            stall_o,
    mem_wb_stage_if.master  dmem,
    output logic            RegWrite_o,
    output logic            MemtoReg_o,
    output logic [XLEN-1:0] ALUout_o,
    output logic [XLEN-1:0] MEMdata_o,
    output logic [4:0]      RDaddr_o,
    output logic            err_o,
    output logic            misalign_o
);

    import cpu_pkg::*;

    localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [1:0]       hwb_q, hwb_d;
    logic [XLEN-1:0]  halu_q, halu_d;
    logic [4:0]       hrd_q, hrd_d;
    logic             err_q, err_d;
    logic             mis_q, mis_d;

    logic             access;
    logic             misalign;
    logic             timeout;
    logic             wb_load;
    logic [1:0]       wb_in;
    logic [XLEN-1:0]  alu_in;
    logic [XLEN-1:0]  mem_in;
    logic [4:0]       rd_in;

    always_comb begin
        access = MEMR_i | MEMW_i;
`ifdef MEM_ALIGN_CHECK_EN
        misalign = access & (ALUout_i[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        timeout = (cnt_q == CNT_W'(ACK_TIMEOUT)) & ~dmem.dmem_ack_i;

        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hwb_d   = hwb_q;
        halu_d  = halu_q;
        hrd_d   = hrd_q;
        err_d   = err_q;
        mis_d   = 1'b0;
        stall_o = 1'b0;
        wb_load = 1'b0;
        wb_in   = WB_i;
        alu_in  = ALUout_i;
        mem_in  = '0;
        rd_in   = RDaddr_i;

        unique case (state_q)
            IDLE: begin
                if (access && !misalign) begin
                    stall_o = 1'b1;
                    state_d = BUSY;
                    cnt_d   = '0;
                    we_d    = MEMW_i;
                    addr_d  = ALUout_i;
                    wdata_d = RS2_i;
                    hwb_d   = WB_i;
                    halu_d  = ALUout_i;
                    hrd_d   = RDaddr_i;
                end else if (misalign) begin
                    mis_d = 1'b1;
                end else begin
                    wb_load = 1'b1;
                end
            end
            BUSY: begin
                // ack wins over a timeout landing on the same cycle
                if (dmem.dmem_ack_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    wb_load = 1'b1;
                    wb_in[WB_REGWRITE] = hwb_q[WB_REGWRITE] & ~we_q;
                    wb_in[WB_MEMTOREG] = hwb_q[WB_MEMTOREG];
                    alu_in  = halu_q;
                    rd_in   = hrd_q;
                    mem_in  = we_q ? '0 : dmem.dmem_rdata_i;
                end else if (timeout) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    stall_o = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hwb_q   <= '0;
            halu_q  <= '0;
            hrd_q   <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hwb_q   <= hwb_d;
            halu_q  <= halu_d;
            hrd_q   <= hrd_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    assign dmem.dmem_req_o   = (state_q == BUSY);
    assign dmem.dmem_we_o    = we_q;
    assign dmem.dmem_addr_o  = addr_q;
    assign dmem.dmem_wdata_o = wdata_q;
    assign err_o             = err_q;
    assign misalign_o        = mis_q;

    mem_wb_reg #(
        .XLEN (XLEN)
    ) u_mem_wb_reg (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_i       (wb_load),
        .wb_i         (wb_in),
        .alu_i        (alu_in),
        .mem_i        (mem_in),
        .rd_i         (rd_in),
        .reg_write_o  (RegWrite_o),
        .mem_to_reg_o (MemtoReg_o),
        .alu_o        (ALUout_o),
        .mem_o        (MEMdata_o),
        .rd_o         (RDaddr_o)
    );

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized scoreboard bench for mem_wb_stage.
// Stimulus pushes expected MEM/WB results and dmem requests; monitor and responder check them.
module tb_mem_wb_stage;

    localparam int TO = 4;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i;
    logic [1:0]  WB_i;
    logic        MEMR_i, MEMW_i;
    logic [31:0] ALUout_i, RS2_i;
    logic [4:0]  RDaddr_i;
    logic        stall_o, RegWrite_o, MemtoReg_o;
    logic [31:0] ALUout_o, MEMdata_o;
    logic [4:0]  RDaddr_o;
    logic        err_o, misalign_o;

    mem_wb_stage_if #(.XLEN(32)) dmem_if ();

    mem_wb_stage #(.ACK_TIMEOUT(TO), .XLEN(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .WB_i       (WB_i),
        .MEMR_i     (MEMR_i),
        .MEMW_i     (MEMW_i),
        .ALUout_i   (ALUout_i),
        .RS2_i      (RS2_i),
        .RDaddr_i   (RDaddr_i),
        .stall_o    (stall_o),
        .dmem       (dmem_if),
        .RegWrite_o (RegWrite_o),
        .MemtoReg_o (MemtoReg_o),
        .ALUout_o   (ALUout_o),
        .MEMdata_o  (MEMdata_o),
        .RDaddr_o   (RDaddr_o),
        .err_o      (err_o),
        .misalign_o (misalign_o)
    );

    typedef struct {
        logic        rw, m2r;
        logic [31:0] alu, mem;
        logic [4:0]  rd;
        logic        mis, err;
    } exp_t;

    typedef struct {
        logic [31:0] addr, wdata, rdata;
        logic        we;
        int          delay, cycles;
    } req_t;

    typedef struct {
        logic [1:0]  wb;
        logic        memr, memw;
        logic [31:0] alu, rs2;
        logic [4:0]  rd;
        int          delay;
        logic [31:0] rdata;
    } instr_t;

    exp_t sbq[$];
    req_t rq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;
    bit   force_ack = 1'b0;
    logic err_exp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic instr_t mk(input logic [1:0] wb, input logic r, input logic w,
                                  input logic [31:0] alu, input logic [31:0] rs2,
                                  input logic [4:0] rd, input int delay, input logic [31:0] rdata);
        instr_t i;
        i.wb = wb; i.memr = r; i.memw = w; i.alu = alu; i.rs2 = rs2;
        i.rd = rd; i.delay = delay; i.rdata = rdata;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        int kind;
        kind = int'($urandom_range(0, 9));
        i.wb = 2'($urandom);
        i.rd = 5'($urandom);
        i.rs2 = $urandom;
        i.rdata = $urandom;
        i.alu = $urandom;
        if ($urandom_range(0, 4) != 0) i.alu[1:0] = 2'b00;
        i.memr = (kind >= 4 && kind < 7) || kind == 9;
        i.memw = kind >= 7;
        i.delay = int'($urandom_range(1, TO + 3));
        return i;
    endfunction

    task automatic set_nop();
        WB_i = 2'b00; MEMR_i = 1'b0; MEMW_i = 1'b0;
        ALUout_i = '0; RS2_i = '0; RDaddr_i = '0;
    endtask

    task automatic scramble();
        WB_i = 2'($urandom); MEMR_i = 1'($urandom); MEMW_i = 1'($urandom);
        ALUout_i = $urandom; RS2_i = $urandom; RDaddr_i = 5'($urandom);
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase.
    task automatic run_instr(input instr_t in);
        exp_t e;
        req_t r;
        bit   acc, st, mis, done;
        logic s;
        int   exp_stalls, stalls;
        acc = in.memr | in.memw;
        st  = in.memw;
        mis = ALIGN_EN && acc && (in.alu[1:0] != 2'b00);
        e.rw = 1'b0; e.m2r = 1'b0; e.alu = '0; e.mem = '0; e.rd = '0; e.mis = mis;
        exp_stalls = 0;
        if (!acc) begin
            e.rw = in.wb[1]; e.m2r = in.wb[0]; e.alu = in.alu; e.rd = in.rd;
        end else if (!mis) begin
            r.addr = in.alu; r.we = st; r.wdata = in.rs2; r.rdata = in.rdata;
            r.delay = in.delay;
            r.cycles = (in.delay <= TO + 1) ? in.delay : TO + 1;
            rq.push_back(r);
            exp_stalls = r.cycles;
            if (in.delay <= TO + 1) begin
                e.rw = in.wb[1] & ~st; e.m2r = in.wb[0]; e.alu = in.alu;
                e.mem = st ? 32'h0 : in.rdata; e.rd = in.rd;
            end else begin
                err_exp = 1'b1;
            end
        end
        e.err = err_exp;
        sbq.push_back(e);
        WB_i = in.wb; MEMR_i = in.memr; MEMW_i = in.memw;
        ALUout_i = in.alu; RS2_i = in.rs2; RDaddr_i = in.rd;
        stalls = 0;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk); #2;
            s = stall_o;
            @(posedge clk);
            if (s) begin
                stalls++;
                #1 scramble();
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL accept_wait: got stall held 64 cycles, want release");
        end
        chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
        #1;
    endtask

    task automatic drain();
        set_nop();
        @(negedge clk); #2;
        mon_en = 1'b0;
        chk("sb_drained", 32'(sbq.size()), 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin : monitor
        bit   adv;
        exp_t e;
        adv = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (!mon_en) begin
                adv = 1'b0;
            end else begin
                if (adv) begin
                    if (sbq.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL sb_empty: got pipeline advance, want none");
                    end else begin
                        e = sbq.pop_front();
                        chk("wb_regwrite", 32'(RegWrite_o), 32'(e.rw));
                        chk("wb_memtoreg", 32'(MemtoReg_o), 32'(e.m2r));
                        chk("wb_aluout", ALUout_o, e.alu);
                        chk("wb_memdata", MEMdata_o, e.mem);
                        chk("wb_rdaddr", 32'(RDaddr_o), 32'(e.rd));
                        chk("misalign", 32'(misalign_o), 32'(e.mis));
                        chk("err", 32'(err_o), 32'(e.err));
                    end
                end else begin
                    chk("bubble_regwrite", 32'(RegWrite_o), 32'h0);
                    chk("bubble_memtoreg", 32'(MemtoReg_o), 32'h0);
                    chk("bubble_rdaddr", 32'(RDaddr_o), 32'h0);
                    chk("bubble_memdata", MEMdata_o, 32'h0);
                    chk("bubble_misalign", 32'(misalign_o), 32'h0);
                end
                adv = !stall_o;
            end
        end
    end

    initial begin : responder
        bit   busy;
        int   k;
        req_t r;
        busy = 1'b0;
        k = 0;
        r.addr = '0; r.wdata = '0; r.rdata = '0; r.we = 1'b0; r.delay = 1; r.cycles = 0;
        dmem_if.dmem_ack_i = 1'b0;
        dmem_if.dmem_rdata_i = '0;
        forever begin
            @(posedge clk); #2;
            if (dmem_if.dmem_req_o) begin
                if (!busy) begin
                    busy = 1'b1;
                    k = 0;
                    if (rq.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_req: got req=1, want req=0");
                        r.delay = 1; r.cycles = 0;
                    end else begin
                        r = rq.pop_front();
                    end
                end
                k++;
                chk("dmem_addr", dmem_if.dmem_addr_o, r.addr);
                chk("dmem_we", 32'(dmem_if.dmem_we_o), 32'(r.we));
                chk("dmem_wdata", dmem_if.dmem_wdata_o, r.wdata);
                dmem_if.dmem_ack_i = (k == r.delay);
                dmem_if.dmem_rdata_i = (k == r.delay) ? r.rdata : $urandom;
            end else begin
                if (busy) begin
                    busy = 1'b0;
                    chk("req_cycles", 32'(k), 32'(r.cycles));
                end
                dmem_if.dmem_ack_i = force_ack | ($urandom_range(0, 3) == 0);
                dmem_if.dmem_rdata_i = $urandom;
            end
        end
    end

    initial begin : watchdog
        #500000;
        n_fail++;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        req_t r;
        rst_i = 1'b0;
        WB_i = 2'b11; MEMR_i = 1'b1; MEMW_i = 1'b1;
        ALUout_i = 32'hFFFF_FFFF; RS2_i = 32'hA5A5_A5A5; RDaddr_i = 5'h1f;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_regwrite", 32'(RegWrite_o), 32'h0);
        chk("rst_memtoreg", 32'(MemtoReg_o), 32'h0);
        chk("rst_aluout", ALUout_o, 32'h0);
        chk("rst_memdata", MEMdata_o, 32'h0);
        chk("rst_rdaddr", 32'(RDaddr_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_misalign", 32'(misalign_o), 32'h0);
        chk("rst_req", 32'(dmem_if.dmem_req_o), 32'h0);
        chk("rst_we", 32'(dmem_if.dmem_we_o), 32'h0);
        chk("rst_addr", dmem_if.dmem_addr_o, 32'h0);
        chk("rst_wdata", dmem_if.dmem_wdata_o, 32'h0);
        rst_i = 1'b1;
        mon_en = 1'b1;

        run_instr(mk(2'b10, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 1, 32'h0));
        run_instr(mk(2'b11, 1'b1, 1'b0, 32'h40, 32'h0, 5'd6, 4, 32'hDEAD_BEEF));
        run_instr(mk(2'b10, 1'b0, 1'b1, 32'h80, 32'hCAFE_F00D, 5'd7, 1, 32'h1111_2222));
        run_instr(mk(2'b11, 1'b1, 1'b0, 32'h100, 32'h0, 5'd8, TO + 1, 32'h5555_AAAA));
        run_instr(mk(2'b11, 1'b1, 1'b1, 32'h84, 32'h7777_8888, 5'd9, 2, 32'h1357_9BDF));
        run_instr(mk(2'b11, 1'b1, 1'b0, 32'h42, 32'h0, 5'd10, 1, 32'h2468_ACE0));
        run_instr(mk(2'b10, 1'b1, 1'b0, 32'h44, 32'h0, 5'd11, 100, 32'h0));
        run_instr(mk(2'b01, 1'b0, 1'b0, 32'hABCD, 32'h0, 5'd12, 1, 32'h0));

        repeat (300) run_instr(rand_instr());
        drain();

        WB_i = 2'b11; MEMR_i = 1'b1; MEMW_i = 1'b0;
        ALUout_i = 32'h100; RS2_i = 32'h0BAD_F00D; RDaddr_i = 5'd7;
        r.addr = 32'h100; r.we = 1'b0; r.wdata = 32'h0BAD_F00D; r.rdata = 32'h0;
        r.delay = 1000; r.cycles = 2;
        rq.push_back(r);
        @(posedge clk); #1;
        chk("busy_req", 32'(dmem_if.dmem_req_o), 32'h1);
        @(posedge clk); #1;
        rst_i = 1'b0;
        set_nop();
        @(posedge clk); #1;
        rst_i = 1'b1;
        err_exp = 1'b0;
        chk("midrst_req", 32'(dmem_if.dmem_req_o), 32'h0);
        chk("midrst_stall", 32'(stall_o), 32'h0);
        chk("midrst_regwrite", 32'(RegWrite_o), 32'h0);
        chk("midrst_memtoreg", 32'(MemtoReg_o), 32'h0);
        chk("midrst_aluout", ALUout_o, 32'h0);
        chk("midrst_memdata", MEMdata_o, 32'h0);
        chk("midrst_rdaddr", 32'(RDaddr_o), 32'h0);
        chk("midrst_err", 32'(err_o), 32'h0);
        chk("midrst_addr", dmem_if.dmem_addr_o, 32'h0);
        force_ack = 1'b1;
        repeat (3) begin
            @(posedge clk); #3;
            chk("late_ack_req", 32'(dmem_if.dmem_req_o), 32'h0);
            chk("late_ack_stall", 32'(stall_o), 32'h0);
            chk("late_ack_regwrite", 32'(RegWrite_o), 32'h0);
            chk("late_ack_memdata", MEMdata_o, 32'h0);
        end
        force_ack = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        run_instr(mk(2'b10, 1'b0, 1'b0, 32'h55AA, 32'h0, 5'd3, 1, 32'h0));
        run_instr(mk(2'b11, 1'b1, 1'b0, 32'h200, 32'h0, 5'd4, 2, 32'h0F0F_F0F0));
        drain();
        repeat (2) @(posedge clk);
        chk("rq_drained", 32'(rq.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
